rom_fetch_sequencer: RTL and testbench
======================================

# rom_fetch_sequencer

Sequences a full read of the 64-bit synchronous-read coefficient ROM, words 0 through NUM_WORDS-1. Each word is unpacked into eight bytes, most-significant byte first, and streamed to a downstream consumer over a valid/ready byte interface. The block sits between the ROM and the compute datapath, and is the only driver of the ROM address.

## Interface
Parameters:
- NUM_WORDS, 9, number of ROM words fetched per run (addresses 0..NUM_WORDS-1)
- ADDR_W, 5, ROM address width
- DATA_W, 64, ROM word width; must equal 8 × BYTES_PER_WORD
- BYTES_PER_WORD, 8, bytes emitted per word

Ports:
- clock  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  synchronous cancel of a run in progress
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  DATA_W  ROM data, valid one cycle after the ROM samples rom_address
- out_data  out  8  current byte
- out_valid  out  1  out_data/out_row/out_col/out_last valid
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready
- out_row  out  4  word index of the current byte
- out_col  out  3  byte index within the word (0 = MSB)
- out_last  out  1  high on the final byte of the run (row NUM_WORDS-1, col 7)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a run completes normally

## Operation
- States: IDLE, ISSUE, CAPTURE, SHIFT, DONE.
- IDLE:
  - If start: rom_address<=0, row<=0, go to ISSUE.
  - Otherwise hold.
- ISSUE: rom_address is stable for this cycle, and the ROM samples it at the closing edge. Go to CAPTURE.
- CAPTURE: rom_q holds the word. shreg<=rom_q, col<=0, go to SHIFT.
- SHIFT:
  - Outputs: out_valid=1, out_data=shreg[DATA_W-1 -: 8].
  - On handshake: shreg<=shreg<<8, col<=col+1.
  - Handshake with col==7 and row==NUM_WORDS-1: go to DONE.
  - Handshake with col==7 and any other row: row<=row+1, rom_address<=rom_address+1, go to ISSUE.
  - No handshake: shreg, col, row and out_data hold.
- DONE: done=1 for this cycle, then go to IDLE.
- start while busy: ignored. No queuing.
- abort in any non-IDLE state: go to IDLE at the next edge. out_valid drops, no done pulse, and a pending byte is discarded. abort has priority over the handshake in the same cycle.
- start and abort asserted together in IDLE: start wins, because abort is a no-op in IDLE.
- out_valid is never deasserted while in SHIFT without a handshake. This is an AXI-style stable-valid rule.

## Timing
- Reset values: state=IDLE, rom_address=0, shreg=0, row=0, col=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- Latency with out_ready held high, where start is sampled at edge E:
  - ISSUE is cycle E+1.
  - First out_valid is in cycle E+3.
  - Each word takes 10 cycles: ISSUE, CAPTURE, then 8 × SHIFT.
  - done is high in cycle E+1+10×NUM_WORDS, which is E+91 for 9 words.
- Backpressure only stretches SHIFT. ISSUE and CAPTURE are fixed at one cycle each.
- Widths:
  - row counts 0..NUM_WORDS-1 and never wraps within a run.
  - col is 3 bits and wraps 7→0 only by leaving SHIFT.
  - rom_address = row, zero-extended to ADDR_W.

## Structure
- Package rom_seq_pkg: state enum type; constants NUM_WORDS, ADDR_W, DATA_W, BYTES_PER_WORD; row and col typedefs.
- Sub-module byte_serializer: parallel-load 64-bit shift register with valid/ready output, a col counter, and a load/last strobe. The FSM in rom_fetch_sequencer drives its load and reads its last-byte-accepted flag.
- The ROM is instantiated outside this block.

## Test plan
- Reset then start, out_ready=1: bytes 0x01..0x08 with row 0 and col 0..7, then 0x11..0x18 with row 1. Final byte is 0x88 with row 8, col 7 and out_last=1. done is high exactly 91 cycles after the start edge.
- Random out_ready (50%): byte sequence identical to the no-stall run, no byte duplicated or dropped, and out_data stable whenever out_valid=1 && out_ready=0.
- start pulsed during SHIFT of row 3: no effect. The run completes with a single done pulse and 72 bytes total.
- abort asserted on row 2, col 4, concurrent with a handshake: next cycle is IDLE with out_valid=0 and no done. A fresh start then restarts at 0x01.
- rst_n dropped mid-run on row 5: all outputs reach reset values immediately, without waiting for a clock edge. After release, start gives a full run from row 0.
- Back-to-back runs: start asserted in the cycle after done produces a second identical 72-byte run, and rom_address returns to 0.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// Shared constants, state encoding and index types for the ROM fetch sequencer.
package rom_seq_pkg;

   localparam int NUM_WORDS      = 9;
   localparam int ADDR_W         = 5;
   localparam int DATA_W         = 64;
   localparam int BYTES_PER_WORD = 8;
   localparam int ROW_W          = 4;
   localparam int COL_W          = 3;

   typedef logic [ROW_W-1:0] row_t;
   typedef logic [COL_W-1:0] col_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_SHIFT   = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/rom_fetch_sequencer_if.sv
// ROM address/data bus plus the downstream valid/ready byte stream.
interface rom_fetch_sequencer_if
   import rom_seq_pkg::*;
#(
   parameter int ADDR_W = rom_seq_pkg::ADDR_W,
   parameter int DATA_W = rom_seq_pkg::DATA_W
);

   logic [ADDR_W-1:0] rom_address;
   logic [DATA_W-1:0] rom_q;
   logic [7:0]        out_data;
   logic              out_valid;
   logic              out_ready;
   row_t              out_row;
   col_t              out_col;
   logic              out_last;

   modport master (
      output rom_address,
      output out_data,
      output out_valid,
      output out_row,
      output out_col,
      output out_last,
      input  rom_q,
      input  out_ready
   );

   modport slave (
      input  rom_address,
      input  out_data,
      input  out_valid,
      input  out_row,
      input  out_col,
      input  out_last,
      output rom_q,
      output out_ready
   );

endinterface

// File: rtl/rom_fetch_sequencer_byte_serializer.sv
// Parallel-load word shift register emitting bytes MSB first over valid/ready.
module byte_serializer
   import rom_seq_pkg::*;
#(
   parameter int WORD_W    = DATA_W,
   parameter int NUM_BYTES = BYTES_PER_WORD
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic              ready_i,
   output logic [7:0]        data_o,
   output logic              valid_o,
   output col_t              col_o,
   output logic              last_acc_o
);

   localparam col_t LAST_COL_C = col_t'(NUM_BYTES - 1);

   logic [WORD_W-1:0] shreg_q, shreg_d;
   col_t              col_q, col_d;
   logic              valid_q, valid_d;
   logic              hs_s;

   // A cleared (aborted) byte never counts as accepted.
   assign hs_s       = valid_q & ready_i & ~clear_i;
   assign last_acc_o = hs_s & (col_q == LAST_COL_C);
   assign data_o     = shreg_q[WORD_W-1 -: 8];
   assign valid_o    = valid_q;
   assign col_o      = col_q;

   // Next-state for shift register, byte index and valid flag.
   always_comb begin
      shreg_d = shreg_q;
      col_d   = col_q;
      valid_d = valid_q;
      if (clear_i) begin
         valid_d = 1'b0;
         col_d   = '0;
      end else if (load_i) begin
         shreg_d = word_i;
         col_d   = '0;
         valid_d = 1'b1;
      end else if (hs_s) begin
         shreg_d = {shreg_q[WORD_W-9:0], 8'h00};
         col_d   = col_q + col_t'(1);
         valid_d = (col_q != LAST_COL_C);
      end else begin
         valid_d = valid_q;
      end
   end

   // Serializer state registers.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= '0;
         col_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         col_q   <= col_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/rom_fetch_sequencer.sv
// Walks ROM words 0..NUM_WORDS-1 and streams each one as eight MSB-first bytes.
module rom_fetch_sequencer #(
   parameter int NUM_WORDS      = rom_seq_pkg::NUM_WORDS,
   parameter int ADDR_W         = rom_seq_pkg::ADDR_W,
   parameter int DATA_W         = rom_seq_pkg::DATA_W,
   parameter int BYTES_PER_WORD = rom_seq_pkg::BYTES_PER_WORD
) (
   input  logic                   clock,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   rom_fetch_sequencer_if.master  bus,
   output logic                   busy,
   output logic                   done
);

   import rom_seq_pkg::*;

   localparam row_t LAST_ROW_C = row_t'(NUM_WORDS - 1);
   localparam col_t LAST_COL_C = col_t'(BYTES_PER_WORD - 1);

   state_e state_q, state_d;
   row_t   row_q, row_d;
   logic   busy_q, done_q;
   logic   abort_s;
   logic   load_s;
   logic   last_acc_s;
   logic   valid_s;
   col_t   col_s;

   assign abort_s = abort & (state_q != ST_IDLE);

   byte_serializer #(
      .WORD_W    (DATA_W),
      .NUM_BYTES (BYTES_PER_WORD)
   ) u_ser (
      .clock      (clock),
      .rst_n      (rst_n),
      .load_i     (load_s),
      .clear_i    (abort_s),
      .word_i     (bus.rom_q),
      .ready_i    (bus.out_ready),
      .data_o     (bus.out_data),
      .valid_o    (valid_s),
      .col_o      (col_s),
      .last_acc_o (last_acc_s)
   );

   // The address is the row counter itself, so it can never diverge from out_row.
   assign bus.rom_address = ADDR_W'(row_q);
   assign bus.out_valid   = valid_s;
   assign bus.out_row     = row_q;
   assign bus.out_col     = col_s;
   assign bus.out_last    = valid_s & (col_s == LAST_COL_C) & (row_q == LAST_ROW_C);
   assign busy            = busy_q;
   assign done            = done_q;

   // Next-state and serializer load; abort overrides every transition.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      load_s  = 1'b0;
      if (abort_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  row_d   = '0;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ISSUE: begin
               state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
               load_s  = 1'b1;
               state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (last_acc_s) begin
                  if (row_q == LAST_ROW_C) begin
                     state_d = ST_DONE;
                  end else begin
                     row_d   = row_q + row_t'(1);
                     state_d = ST_ISSUE;
                  end
               end else begin
                  state_d = ST_SHIFT;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State, row and registered status flags.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed bench for rom_fetch_sequencer with a byte-index stream model.
module tb_rom_fetch_sequencer;

   logic clock = 1'b0;
   logic rst_n;
   logic start;
   logic abort;
   logic busy;
   logic done;

   rom_fetch_sequencer_if #(.ADDR_W(5), .DATA_W(64)) bus ();

   rom_fetch_sequencer dut (
      .clock (clock),
      .rst_n (rst_n),
      .start (start),
      .abort (abort),
      .bus   (bus.master),
      .busy  (busy),
      .done  (done)
   );

   always #5 clock = ~clock;

   // ROM word w holds bytes {w, 1}..{w, 8}, MSB first.
   function automatic logic [63:0] rom_word(input logic [4:0] a);
      logic [63:0] w;
      w = 64'd0;
      for (int b = 0; b < 8; b++) w = {w[55:0], a[3:0], 4'(b + 1)};
      return w;
   endfunction

   always @(posedge clock) bus.rom_q <= rom_word(bus.rom_address);

   int tests = 0;
   int fails = 0;
   int cyc_cnt = 0;
   int idx;
   int done_cnt;
   int done_cyc;
   int first_valid_cyc;
   logic stall_prev;
   logic [7:0] stall_data;
   logic [7:0] got [0:71];

   task automatic clear_model();
      idx = 0;
      done_cnt = 0;
      done_cyc = -1;
      first_valid_cyc = -1;
      stall_prev = 1'b0;
      stall_data = 8'h00;
      for (int i = 0; i < 72; i++) got[i] = 8'hxx;
   endtask

   // Byte idx of a run is row idx/8, col idx%8, data {row, col+1}.
   task automatic check_cycle();
      logic [7:0] ed;
      logic [3:0] er;
      logic [2:0] ec;
      logic       el;
      cyc_cnt++;
      if (stall_prev) begin
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== stall_data) begin
            fails++;
            $display("FAIL stall_hold: got valid=%0b data=%02h, want valid=1 data=%02h",
                     bus.out_valid, bus.out_data, stall_data);
         end
      end
      if (bus.out_valid === 1'b1) begin
         if (first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
         er = 4'(idx / 8);
         ec = 3'(idx % 8);
         ed = {er, 4'((idx % 8) + 1)};
         el = (idx == 71);
         tests++;
         if (idx > 71 || {bus.out_data, bus.out_row, bus.out_col, bus.out_last} !== {ed, er, ec, el}) begin
            fails++;
            $display("FAIL stream[%0d]: got data=%02h row=%0d col=%0d last=%0b, want data=%02h row=%0d col=%0d last=%0b",
                     idx, bus.out_data, bus.out_row, bus.out_col, bus.out_last, ed, er, ec, el);
         end
         if (bus.out_ready) begin
            if (idx < 72) got[idx] = bus.out_data;
            idx++;
         end
      end
      stall_prev = (bus.out_valid === 1'b1) && !bus.out_ready;
      stall_data = bus.out_data;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc_cnt;
      end
   endtask

   task automatic cyc();
      @(negedge clock);
      check_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic check_val(input string name, input int actual, input int want);
      tests++;
      if (actual != want) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, actual, want);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      logic [23:0] v;
      v = {busy, done, bus.out_valid, bus.out_last, bus.out_data, bus.out_row, bus.out_col, bus.rom_address};
      tests++;
      if (v !== 24'd0) begin
         fails++;
         $display("FAIL %s: got outputs %06h, want 000000", name, v);
      end
   endtask

   task automatic do_run(input bit random_ready, input bit inject, input bit check_timing);
      int  base;
      int  n;
      bit  injected;
      clear_model();
      start = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      start = 1'b0;
      base = cyc_cnt;
      check_val("rom_address_at_issue", int'(bus.rom_address), 0);
      n = 0;
      injected = 1'b0;
      while (done_cnt == 0 && n < 2000) begin
         bus.out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (inject && !injected && bus.out_valid === 1'b1 && bus.out_row == 4'd3) begin
            start = 1'b1;
            injected = 1'b1;
         end else begin
            start = 1'b0;
         end
         cyc();
         n++;
      end
      start = 1'b0;
      bus.out_ready = 1'b1;
      check_val("run_done_seen", done_cnt, 1);
      check_val("run_byte_count", idx, 72);
      if (check_timing) begin
         check_val("done_latency", done_cyc - base, 91);
         check_val("first_valid_latency", first_valid_cyc - base, 3);
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      bus.out_ready = 1'b0;
      clear_model();
      repeat (2) @(posedge clock);
      #1;
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      cyc();

      // Plain run with literal pins on the captured stream.
      do_run(1'b0, 1'b0, 1'b1);
      check_val("pin_byte0", int'(got[0]), 8'h01);
      check_val("pin_byte1", int'(got[1]), 8'h02);
      check_val("pin_byte8", int'(got[8]), 8'h11);
      check_val("pin_byte71", int'(got[71]), 8'h88);

      // Random backpressure.
      cyc();
      do_run(1'b1, 1'b0, 1'b0);

      // start pulsed during row 3 has no effect.
      cyc();
      do_run(1'b0, 1'b1, 1'b1);
      repeat (3) cyc();
      check_val("single_done_pulse", done_cnt, 1);
      check_val("idle_after_run", int'(busy), 0);

      // Abort at row 2, col 4 together with a handshake.
      clear_model();
      start = 1'b1;
      cyc();
      start = 1'b0;
      n = 0;
      while (!(bus.out_valid === 1'b1 && bus.out_row == 4'd2 && bus.out_col == 3'd4) && n < 500) begin
         cyc();
         n++;
      end
      check_val("abort_point_reached", int'(n < 500), 1);
      abort = 1'b1;
      bus.out_ready = 1'b1;
      cyc();
      abort = 1'b0;
      check_val("abort_valid_drop", int'(bus.out_valid), 0);
      check_val("abort_busy_drop", int'(busy), 0);
      repeat (4) cyc();
      check_val("abort_no_done", done_cnt, 0);
      do_run(1'b0, 1'b0, 1'b1);
      check_val("restart_byte0", int'(got[0]), 8'h01);

      // Asynchronous reset mid-run on row 5.
      cyc();
      clear_model();
      start = 1'b1;
      cyc();
      start = 1'b0;
      n = 0;
      while (!(bus.out_valid === 1'b1 && bus.out_row == 4'd5) && n < 500) begin
         cyc();
         n++;
      end
      check_val("row5_reached", int'(n < 500), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset_mid_run");
      @(posedge clock);
      #1;
      rst_n = 1'b1;
      cyc();
      do_run(1'b0, 1'b0, 1'b1);

      // Back-to-back: second start in the cycle right after done.
      cyc();
      do_run(1'b0, 1'b0, 1'b1);
      do_run(1'b0, 1'b0, 1'b1);
      check_val("b2b_byte0", int'(got[0]), 8'h01);
      repeat (3) cyc();
      check_val("b2b_single_done", done_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
